multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_alu.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu: single-issue ALU with iterative multiply and divide.
//   Single-cycle ops (logic, add/sub, compares, shifts, LUI, MFHI/MFLO)
//   register their result into BusW one cycle after acceptance. MULT/MULTU
//   (shift-add) and DIV/DIVU (restoring) take WIDTH iterations plus one
//   finishing cycle, then update HI, LO and BusW together.
// Ports:
//   CLK, Reset_L          clock, async active-low reset
//   InValid / InReady     request handshake (ALUCtrl, BusA, BusB)
//   OutValid / OutReady   result handshake (BusW, Zero)
//   HI, LO                high product / remainder, low product / quotient
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             InValid,
  output logic             InReady,
  input  logic [4:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] BusW,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_SLL   = 5'b00011;
  localparam logic [4:0] OP_SRL   = 5'b00100;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_SLT   = 5'b00111;
  localparam logic [4:0] OP_ADDU  = 5'b01000;
  localparam logic [4:0] OP_SUBU  = 5'b01001;
  localparam logic [4:0] OP_XOR   = 5'b01010;
  localparam logic [4:0] OP_SLTU  = 5'b01011;
  localparam logic [4:0] OP_NOR   = 5'b01100;
  localparam logic [4:0] OP_SRA   = 5'b01101;
  localparam logic [4:0] OP_LUI   = 5'b01110;
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MFHI  = 5'b10100;
  localparam logic [4:0] OP_MFLO  = 5'b10101;

  localparam logic [SHW:0] ITERS = (SHW+1)'(WIDTH);

  logic [1:0]         state;
  logic [SHW:0]       cnt;
  logic [2*WIDTH-1:0] acc;       // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   mreg;      // multiplicand or divisor magnitude
  logic               neg_lo;    // negate product / quotient at finish
  logic               neg_hi;    // negate remainder at finish
  logic               div_zero;

  logic               accept, is_mul, is_div, is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag, alu_res;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_neg;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

  assign InReady   = (state == IDLE) && (!OutValid || OutReady);
  assign accept    = InValid && InReady;
  assign Zero      = (BusW == '0);
  assign is_mul    = (ALUCtrl == OP_MULT) || (ALUCtrl == OP_MULTU);
  assign is_div    = (ALUCtrl == OP_DIV)  || (ALUCtrl == OP_DIVU);
  assign is_signed = (ALUCtrl == OP_MULT) || (ALUCtrl == OP_DIV);
  assign a_mag     = (is_signed && BusA[WIDTH-1]) ? -BusA : BusA;
  assign b_mag     = (is_signed && BusB[WIDTH-1]) ? -BusB : BusB;

  always_comb begin
    alu_res = '0;
    case (ALUCtrl)
      OP_AND:  alu_res = BusA & BusB;
      OP_OR:   alu_res = BusA | BusB;
      OP_ADD,
      OP_ADDU: alu_res = BusA + BusB;
      OP_SUB,
      OP_SUBU: alu_res = BusA - BusB;
      OP_SLT:  alu_res[0] = $signed(BusA) < $signed(BusB);
      OP_SLTU: alu_res[0] = BusA < BusB;
      OP_XOR:  alu_res = BusA ^ BusB;
      OP_NOR:  alu_res = ~(BusA | BusB);
      OP_SLL:  alu_res = BusB << BusA[SHW-1:0];
      OP_SRL:  alu_res = BusB >> BusA[SHW-1:0];
      OP_SRA:  alu_res = $signed(BusB) >>> BusA[SHW-1:0];
      OP_LUI:  alu_res = {BusB[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI: alu_res = HI;
      OP_MFLO: alu_res = LO;
      default: alu_res = '0;
    endcase
  end

  // One iteration of either algorithm. The divide subtract only needs WIDTH
  // bits: it is used only when the shifted remainder is >= divisor, so the
  // true difference is already below the divisor.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mreg & {WIDTH{acc[0]}}};
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_sh[WIDTH-1:0] - mreg;
    div_neg  = div_sh < {1'b0, mreg};
    if (state == MUL)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else
      acc_step = {(div_neg ? div_sh[WIDTH-1:0] : div_diff), acc[WIDTH-2:0], ~div_neg};
  end

  // Divide by zero leaves |dividend| as the remainder, so the normal sign
  // fix already yields HI = BusA; only the quotient needs forcing.
  always_comb begin
    prod_fix = neg_lo ? -acc : acc;
    quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (state == MUL) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else begin
      res_hi = rem_fix;
      res_lo = div_zero ? '1 : quo_fix;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state    <= IDLE;
      OutValid <= 1'b0;
      BusW     <= '0;
      HI       <= '0;
      LO       <= '0;
      cnt      <= '0;
      acc      <= '0;
      mreg     <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (is_mul || is_div)) begin
            state    <= is_mul ? MUL : DIV;
            OutValid <= 1'b0;
            cnt      <= '0;
            acc      <= {{WIDTH{1'b0}}, (is_mul ? b_mag : a_mag)};
            mreg     <= is_mul ? a_mag : b_mag;
            neg_lo   <= is_signed && (BusA[WIDTH-1] ^ BusB[WIDTH-1]);
            neg_hi   <= is_signed && BusA[WIDTH-1];
            div_zero <= (BusB == '0);
          end else if (accept) begin
            BusW     <= alu_res;
            OutValid <= 1'b1;
            if (!OutReady) state <= HOLD;
          end else if (OutReady) begin
            OutValid <= 1'b0;
          end
        end
        MUL, DIV: begin
          if (cnt == ITERS) begin
            HI       <= res_hi;
            LO       <= res_lo;
            BusW     <= res_lo;
            OutValid <= 1'b1;
            cnt      <= '0;
            state    <= HOLD;
          end else begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (OutValid && OutReady) begin
            state    <= IDLE;
            OutValid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

  localparam logic [4:0] AND_  = 5'b00000;
  localparam logic [4:0] OR_   = 5'b00001;
  localparam logic [4:0] ADD   = 5'b00010;
  localparam logic [4:0] SLL   = 5'b00011;
  localparam logic [4:0] SRL   = 5'b00100;
  localparam logic [4:0] SUB   = 5'b00110;
  localparam logic [4:0] SLT   = 5'b00111;
  localparam logic [4:0] ADDU  = 5'b01000;
  localparam logic [4:0] SUBU  = 5'b01001;
  localparam logic [4:0] XOR_  = 5'b01010;
  localparam logic [4:0] SLTU  = 5'b01011;
  localparam logic [4:0] NOR_  = 5'b01100;
  localparam logic [4:0] SRA   = 5'b01101;
  localparam logic [4:0] LUI   = 5'b01110;
  localparam logic [4:0] MULT  = 5'b10000;
  localparam logic [4:0] MULTU = 5'b10001;
  localparam logic [4:0] DIV   = 5'b10010;
  localparam logic [4:0] DIVU  = 5'b10011;
  localparam logic [4:0] MFHI  = 5'b10100;
  localparam logic [4:0] MFLO  = 5'b10101;

  logic        CLK, Reset_L, InValid, InReady, OutValid, OutReady, Zero;
  logic [4:0]  ALUCtrl;
  logic [31:0] BusA, BusB, BusW, HI, LO;

  int n_cmp, n_err;

  multicycle_alu #(.WIDTH(32), .SHW(5)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .InValid(InValid), .InReady(InReady),
    .ALUCtrl(ALUCtrl), .BusA(BusA), .BusB(BusB), .OutValid(OutValid),
    .OutReady(OutReady), .BusW(BusW), .HI(HI), .LO(LO), .Zero(Zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    InValid = 1'b1;
    ALUCtrl = op;
    BusA    = a;
    BusB    = b;
  endtask

  task automatic run_long(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
    drive(op, a, b);
    tick();
    drive(ADD, 32'h1, 32'h1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (OutValid === 1'b1) begin
        lat = k;
        break;
      end
    end
    InValid = 1'b0;
  endtask

  task automatic test_reset();
    Reset_L = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    ALUCtrl = '0; BusA = '0; BusB = '0;
    tick();
    n_cmp++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL reset OutValid: got %b expected 0", OutValid); end
    n_cmp++; if (BusW !== 32'h0) begin n_err++; $display("FAIL reset BusW: got %h expected 00000000", BusW); end
    n_cmp++; if (HI !== 32'h0 || LO !== 32'h0) begin n_err++; $display("FAIL reset HI/LO: got %h/%h expected 0/0", HI, LO); end
    n_cmp++; if (Zero !== 1'b1) begin n_err++; $display("FAIL reset Zero: got %b expected 1", Zero); end
    Reset_L = 1'b1;
    tick();
    n_cmp++; if (InReady !== 1'b1) begin n_err++; $display("FAIL reset release InReady: got %b expected 1", InReady); end
  endtask

  task automatic test_add_overflow();
    OutReady = 1'b1;
    drive(ADD, 32'h7FFFFFFF, 32'h00000001);
    tick();
    InValid = 1'b0;
    n_cmp++; if (OutValid !== 1'b1) begin n_err++; $display("FAIL add latency OutValid: got %b expected 1", OutValid); end
    n_cmp++; if (BusW !== 32'h80000000) begin n_err++; $display("FAIL add BusW: got %h expected 80000000", BusW); end
    n_cmp++; if (Zero !== 1'b0) begin n_err++; $display("FAIL add Zero: got %b expected 0", Zero); end
    tick();
    n_cmp++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL add drain OutValid: got %b expected 0", OutValid); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  op [23];
    logic [31:0] a [23];
    logic [31:0] b [23];
    logic [31:0] w [23];
    op = '{AND_, OR_, ADD, SLL, SRL, SUB, SLT, ADDU, SUBU, XOR_, SLTU, NOR_,
           SRA, LUI, 5'b00101, SLL, SRL, SLTU, SLT, SRA, SUB, 5'b11111, SRA};
    a  = '{32'hF0F01234, 32'hF0000000, 32'hFFFFFFFF, 32'h00000004, 32'h00000004, 32'h00000005,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hAAAA5555, 32'hFFFFFFFF, 32'hF0F0F0F0,
           32'h00000004, 32'h00000000, 32'h00000005, 32'h00000024, 32'h0000001F, 32'h00000001,
           32'h00000001, 32'h0000001F, 32'h00000000, 32'hFFFFFFFF, 32'h0000001F};
    b  = '{32'h0FF0FFFF, 32'h0000000F, 32'hFFFFFFFF, 32'h00000003, 32'h80000000, 32'h00000005,
           32'h00000001, 32'h00000002, 32'h00000001, 32'hFFFF0000, 32'h00000001, 32'h0F0F0000,
           32'h80000000, 32'h1234ABCD, 32'h00000007, 32'h00000001, 32'h80000000, 32'hFFFFFFFF,
           32'hFFFFFFFF, 32'h40000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    w  = '{32'h00F01234, 32'hF000000F, 32'hFFFFFFFE, 32'h00000030, 32'h08000000, 32'h00000000,
           32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'h55555555, 32'h00000000, 32'h00000F0F,
           32'hF8000000, 32'hABCD0000, 32'h00000000, 32'h00000010, 32'h00000001, 32'h00000001,
           32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    OutReady = 1'b1;
    for (int i = 0; i < 23; i++) begin
      drive(op[i], a[i], b[i]);
      n_cmp++; if (InReady !== 1'b1) begin n_err++; $display("FAIL b2b[%0d] InReady: got %b expected 1", i, InReady); end
      tick();
      n_cmp++;
      if (OutValid !== 1'b1 || BusW !== w[i] || Zero !== (w[i] == 32'h0)) begin
        n_err++;
        $display("FAIL b2b[%0d] op %b: got valid=%b BusW=%h Zero=%b expected 1/%h/%b",
                 i, op[i], OutValid, BusW, Zero, w[i], (w[i] == 32'h0));
      end
    end
    InValid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    OutReady = 1'b1;
    drive(ADD, 32'd3, 32'd4);
    tick();
    drive(SUB, 32'd9, 32'd4);
    OutReady = 1'b0;
    #1;
    n_cmp++; if (InReady !== 1'b0) begin n_err++; $display("FAIL stall InReady: got %b expected 0", InReady); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (OutValid !== 1'b1 || BusW !== 32'd7 || Zero !== 1'b0 || InReady !== 1'b0) begin
        n_err++;
        $display("FAIL stall cycle %0d: got valid=%b BusW=%h Zero=%b InReady=%b expected 1/00000007/0/0",
                 c, OutValid, BusW, Zero, InReady);
      end
    end
    OutReady = 1'b1;
    #1;
    n_cmp++; if (InReady !== 1'b1) begin n_err++; $display("FAIL stall release InReady: got %b expected 1", InReady); end
    tick();
    InValid = 1'b0;
    n_cmp++;
    if (OutValid !== 1'b1 || BusW !== 32'd5) begin
      n_err++; $display("FAIL stall next op: got valid=%b BusW=%h expected 1/00000005", OutValid, BusW);
    end
    tick();
    n_cmp++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL stall drain OutValid: got %b expected 0", OutValid); end
    OutReady = 1'b0;
    drive(XOR_, 32'h000000FF, 32'h000000FF);
    tick();
    InValid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_cmp++;
      if (OutValid !== 1'b1 || BusW !== 32'h0 || Zero !== 1'b1 || InReady !== 1'b0) begin
        n_err++;
        $display("FAIL hold cycle %0d: got valid=%b BusW=%h Zero=%b InReady=%b expected 1/00000000/1/0",
                 c, OutValid, BusW, Zero, InReady);
      end
      tick();
    end
    OutReady = 1'b1;
    tick();
    n_cmp++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      n_err++; $display("FAIL hold release: got valid=%b InReady=%b expected 0/1", OutValid, InReady);
    end
  endtask

  task automatic test_muldiv();
    int lat;
    logic [4:0]  op [11];
    logic [31:0] a [11];
    logic [31:0] b [11];
    logic [31:0] hi [11];
    logic [31:0] lo [11];
    op = '{DIV, DIVU, DIV, DIV, DIVU, DIV, MULTU, MULT, MULT, DIVU, MULT};
    a  = '{32'hFFFFFFF9, 32'h00001234, 32'h80000000, 32'hFFFFFFF0, 32'h00000064, 32'h00000007,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00010000};
    b  = '{32'h00000002, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000007, 32'hFFFFFFFE,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h00010000};
    hi = '{32'hFFFFFFFF, 32'h00001234, 32'h00000000, 32'hFFFFFFF0, 32'h00000002, 32'h00000001,
           32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    lo = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0000000E, 32'hFFFFFFFD,
           32'h00000001, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    OutReady = 1'b1;
    for (int i = 0; i < 11; i++) begin
      run_long(op[i], a[i], b[i], lat);
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL muldiv[%0d] latency: got %0d expected 33", i, lat); end
      n_cmp++; if (HI !== hi[i]) begin n_err++; $display("FAIL muldiv[%0d] HI: got %h expected %h", i, HI, hi[i]); end
      n_cmp++; if (LO !== lo[i]) begin n_err++; $display("FAIL muldiv[%0d] LO: got %h expected %h", i, LO, lo[i]); end
      n_cmp++;
      if (BusW !== lo[i] || Zero !== (lo[i] == 32'h0)) begin
        n_err++; $display("FAIL muldiv[%0d] BusW/Zero: got %h/%b expected %h/%b", i, BusW, Zero, lo[i], (lo[i] == 32'h0));
      end
      tick();
      n_cmp++;
      if (OutValid !== 1'b0 || BusW !== lo[i]) begin
        n_err++; $display("FAIL muldiv[%0d] drop request: got valid=%b BusW=%h expected 0/%h", i, OutValid, BusW, lo[i]);
      end
    end
  endtask

  task automatic test_mul_mfhi();
    int lat;
    OutReady = 1'b1;
    run_long(MULT, 32'hFFFFFFFD, 32'h00000005, lat);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mult latency: got %0d expected 33", lat); end
    n_cmp++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFF1 || BusW !== 32'hFFFFFFF1) begin
      n_err++; $display("FAIL mult result: got HI=%h LO=%h BusW=%h expected FFFFFFFF/FFFFFFF1/FFFFFFF1", HI, LO, BusW);
    end
    tick();
    drive(MFHI, 32'h0, 32'h0);
    tick();
    n_cmp++; if (OutValid !== 1'b1 || BusW !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mfhi: got valid=%b BusW=%h expected 1/FFFFFFFF", OutValid, BusW); end
    drive(MFLO, 32'h0, 32'h0);
    tick();
    n_cmp++; if (OutValid !== 1'b1 || BusW !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mflo: got valid=%b BusW=%h expected 1/FFFFFFF1", OutValid, BusW); end
    drive(ADD, 32'd1, 32'd2);
    tick();
    InValid = 1'b0;
    n_cmp++;
    if (BusW !== 32'd3 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFF1) begin
      n_err++; $display("FAIL hilo hold: got BusW=%h HI=%h LO=%h expected 00000003/FFFFFFFF/FFFFFFF1", BusW, HI, LO);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    logic bad;
    OutReady = 1'b1;
    drive(MULT, 32'd3, 32'd5);
    tick();
    InValid = 1'b0;
    repeat (10) tick();
    Reset_L = 1'b0;
    #1;
    n_cmp++;
    if (OutValid !== 1'b0 || HI !== 32'h0 || LO !== 32'h0 || BusW !== 32'h0 || Zero !== 1'b1) begin
      n_err++; $display("FAIL abort reset: got valid=%b HI=%h LO=%h BusW=%h Zero=%b expected 0/0/0/0/1",
                        OutValid, HI, LO, BusW, Zero);
    end
    tick();
    tick();
    Reset_L = 1'b1;
    tick();
    n_cmp++;
    if (InReady !== 1'b1 || OutValid !== 1'b0) begin
      n_err++; $display("FAIL abort release: got InReady=%b valid=%b expected 1/0", InReady, OutValid);
    end
    bad = 1'b0;
    repeat (40) begin
      tick();
      if (OutValid !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) bad = 1'b1;
    end
    n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL abort leak: got late result flag %b expected 0", bad); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_backpressure();
    test_muldiv();
    test_mul_mfhi();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
